// File: rtl/elevator_call_scheduler_if.sv
// Call-scheduler bus between the scheduler, the call panel and the motion block.
// master drives calls and car position; slave is the scheduler.
interface elevator_call_scheduler_if #(
    parameter int NUM_FLOORS = 9
);
    logic [NUM_FLOORS-1:0] call_req;
    logic [3:0]            cur_floor;
    logic                  arrived;
    logic [3:0]            target_floor;
    logic                  target_valid;
    logic                  door_open;
    logic                  dir_up;
    logic [NUM_FLOORS-1:0] pending;
    logic                  idle;

    modport master (
        output call_req,
        output cur_floor,
        output arrived,
        input  target_floor,
        input  target_valid,
        input  door_open,
        input  dir_up,
        input  pending,
        input  idle
    );

    modport slave (
        input  call_req,
        input  cur_floor,
        input  arrived,
        output target_floor,
        output target_valid,
        output door_open,
        output dir_up,
        output pending,
        output idle
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// LOOK-policy elevator call scheduler: latches floor calls, issues travel
// targets to the motion block and times the door at each stop.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS  = 9,
    parameter int DOOR_CYCLES = 16
) (
    input logic clk,
    input logic rst_n,
    elevator_call_scheduler_if.slave bus
);
    localparam int CW = $clog2(DOOR_CYCLES + 1);
    localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SERVE,
        S_DOOR
    } state_t;

    state_t                state_q;
    logic [NUM_FLOORS-1:0] pending_q;
    logic [3:0]            target_q;
    logic                  tvalid_q;
    logic                  door_q;
    logic                  dir_q;
    logic                  idle_q;
    logic [CW-1:0]         cnt_q;

    logic                  in_range;
    logic [NUM_FLOORS-1:0] cur_mask;
    logic [NUM_FLOORS-1:0] pending_nxt;
    logic                  clear_en;
    logic                  go_idle;
    logic                  up_hit;
    logic                  dn_hit;
    logic [3:0]            up_floor;
    logic [3:0]            dn_floor;
    logic                  at_target;

    assign in_range  = {1'b0, bus.cur_floor} < 5'(NUM_FLOORS);
    assign at_target = bus.arrived && (bus.cur_floor == target_q);

    always_comb begin
        cur_mask = '0;
        if (in_range) begin
            cur_mask = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << bus.cur_floor;
        end
    end

    // Nearest outstanding floor on each side of the car.
    always_comb begin
        up_hit   = 1'b0;
        up_floor = '0;
        dn_hit   = 1'b0;
        dn_floor = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (4'(i) > bus.cur_floor)) begin
                up_hit   = 1'b1;
                up_floor = 4'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (4'(i) < bus.cur_floor)) begin
                dn_hit   = 1'b1;
                dn_floor = 4'(i);
            end
        end
    end

    // While the door is open, calls at the car's floor are swallowed.
    always_comb begin
        clear_en = 1'b0;
        go_idle  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                clear_en = |(pending_q & cur_mask);
                go_idle  = !(in_range && (|pending_q));
            end
            S_SERVE: begin
                clear_en = in_range && at_target;
            end
            S_DOOR: begin
                clear_en = in_range;
                go_idle  = in_range && (cnt_q == '0);
            end
            default: begin
                clear_en = 1'b0;
                go_idle  = 1'b0;
            end
        endcase
    end

    assign pending_nxt = (pending_q | bus.call_req)
                       & ~(clear_en ? cur_mask : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            target_q  <= '0;
            tvalid_q  <= 1'b0;
            door_q    <= 1'b0;
            dir_q     <= 1'b1;
            idle_q    <= 1'b1;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_nxt;
            idle_q    <= go_idle && (pending_nxt == '0);
            if (in_range) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (|(pending_q & cur_mask)) begin
                            state_q <= S_DOOR;
                            door_q  <= 1'b1;
                            cnt_q   <= DOOR_LOAD;
                        end else if (|pending_q) begin
                            state_q  <= S_SERVE;
                            tvalid_q <= 1'b1;
                            if (dir_q) begin
                                if (up_hit) begin
                                    target_q <= up_floor;
                                end else begin
                                    target_q <= dn_floor;
                                    dir_q    <= 1'b0;
                                end
                            end else begin
                                if (dn_hit) begin
                                    target_q <= dn_floor;
                                end else begin
                                    target_q <= up_floor;
                                    dir_q    <= 1'b1;
                                end
                            end
                        end
                    end
                    S_SERVE: begin
                        if (at_target) begin
                            state_q  <= S_DOOR;
                            tvalid_q <= 1'b0;
                            door_q   <= 1'b1;
                            cnt_q    <= DOOR_LOAD;
                        end else if (dir_q && up_hit
                                     && (up_floor < target_q)) begin
                            target_q <= up_floor;
                        end else if (!dir_q && dn_hit
                                     && (dn_floor > target_q)) begin
                            target_q <= dn_floor;
                        end
                    end
                    S_DOOR: begin
                        if (cnt_q == '0) begin
                            state_q <= S_IDLE;
                            door_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.pending      = pending_q;
    assign bus.target_floor = target_q;
    assign bus.target_valid = tvalid_q;
    assign bus.door_open    = door_q;
    assign bus.dir_up       = dir_q;
    assign bus.idle         = idle_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: directed scenarios plus a random
// motion/call run, all compared against a floor-list reference model.
module tb_elevator_call_scheduler;
    localparam int NF = 9;
    localparam int DC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    elevator_call_scheduler_if #(.NUM_FLOORS(NF)) bus ();

    elevator_call_scheduler #(
        .NUM_FLOORS (NF),
        .DOOR_CYCLES(DC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 waiting, 1 travelling, 2 doors open.
    int m_mode;
    bit m_calls[NF];
    int m_tgt;
    bit m_tv;
    bit m_door;
    bit m_dir;
    bit m_idle;
    int m_left;

    function automatic int nearest_above(int cf);
        for (int f = cf + 1; f < NF; f++)
            if (m_calls[f]) return f;
        return -1;
    endfunction

    function automatic int nearest_below(int cf);
        for (int f = cf - 1; f >= 0; f--)
            if (m_calls[f]) return f;
        return -1;
    endfunction

    function automatic logic [NF-1:0] calls_vec();
        logic [NF-1:0] v;
        for (int f = 0; f < NF; f++) v[f] = m_calls[f];
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        for (int f = 0; f < NF; f++) m_calls[f] = 1'b0;
        m_tgt  = 0;
        m_tv   = 1'b0;
        m_door = 1'b0;
        m_dir  = 1'b1;
        m_idle = 1'b1;
        m_left = 0;
    endtask

    task automatic model_tick(input logic [NF-1:0] calls,
                              input int cf, input bit arr);
        int clr;
        int up;
        int dn;
        bit any;
        clr = -1;
        any = (calls_vec() != '0);
        if (cf < NF) begin
            up = nearest_above(cf);
            dn = nearest_below(cf);
            if (m_mode == 0) begin
                if (m_calls[cf]) begin
                    m_mode = 2; clr = cf; m_door = 1'b1; m_left = DC;
                end else if (any) begin
                    m_mode = 1; m_tv = 1'b1;
                    if (m_dir && up >= 0) m_tgt = up;
                    else if (m_dir) begin m_tgt = dn; m_dir = 1'b0; end
                    else if (dn >= 0) m_tgt = dn;
                    else begin m_tgt = up; m_dir = 1'b1; end
                end
            end else if (m_mode == 1) begin
                if (arr && cf == m_tgt) begin
                    m_mode = 2; clr = cf; m_tv = 1'b0;
                    m_door = 1'b1; m_left = DC;
                end else if (m_dir && up >= 0 && up < m_tgt) begin
                    m_tgt = up;
                end else if (!m_dir && dn >= 0 && dn > m_tgt) begin
                    m_tgt = dn;
                end
            end else begin
                clr = cf;
                m_left--;
                if (m_left == 0) begin m_mode = 0; m_door = 1'b0; end
            end
        end
        for (int f = 0; f < NF; f++)
            m_calls[f] = (m_calls[f] || calls[f]) && (f != clr);
        m_idle = (m_mode == 0) && (calls_vec() == '0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("pending", 32'(bus.pending), 32'(calls_vec()));
        chk("target_valid", 32'(bus.target_valid), 32'(m_tv));
        chk("door_open", 32'(bus.door_open), 32'(m_door));
        chk("dir_up", 32'(bus.dir_up), 32'(m_dir));
        chk("idle", 32'(bus.idle), 32'(m_idle));
        chk("target_floor", 32'(bus.target_floor), 32'(m_tgt));
        chk("door_tv_excl", 32'(bus.door_open & bus.target_valid), 32'd0);
    endtask

    task automatic step(input logic [NF-1:0] calls, input int cf,
                        input bit arr);
        bus.call_req  = calls;
        bus.cur_floor = 4'(cf);
        bus.arrived   = arr;
        @(posedge clk);
        model_tick(calls, cf, arr);
        #1;
        compare_all();
    endtask

    task automatic ride(input int from, input int to);
        int f;
        f = from;
        while (f != to) begin
            f = (to > f) ? f + 1 : f - 1;
            step('0, f, f == to);
        end
    endtask

    task automatic door_wait(input int cf, input logic [NF-1:0] first);
        int n;
        n = 0;
        while (bus.door_open && n < 100) begin
            step(n == 0 ? first : '0, cf, 1'b0);
            n++;
        end
        chk("door_len", 32'(n), 32'(DC));
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_pending"}, 32'(bus.pending), 32'd0);
        chk({tag, "_target"}, 32'(bus.target_floor), 32'd0);
        chk({tag, "_tvalid"}, 32'(bus.target_valid), 32'd0);
        chk({tag, "_door"}, 32'(bus.door_open), 32'd0);
        chk({tag, "_dir"}, 32'(bus.dir_up), 32'd1);
        chk({tag, "_idle"}, 32'(bus.idle), 32'd1);
    endtask

    initial begin
        logic [NF-1:0] calls;
        int pos;
        int cfd;
        bit arr;
        bus.call_req  = '0;
        bus.cur_floor = '0;
        bus.arrived   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_vals("por");
        #2 rst_n = 1'b1;

        // Single call from the lobby, two-cycle latency, full door time.
        step(NF'(1) << 5, 0, 1'b0);
        step('0, 0, 1'b0);
        chk("lat_target", 32'(bus.target_floor), 32'd5);
        chk("lat_tvalid", 32'(bus.target_valid), 32'd1);
        chk("lat_dir", 32'(bus.dir_up), 32'd1);
        ride(0, 5);
        chk("arr5_door", 32'(bus.door_open), 32'd1);
        door_wait(5, '0);
        chk("arr5_idle", 32'(bus.idle), 32'd1);

        // Calls on both sides while heading up.
        step((NF'(1) << 2) | (NF'(1) << 6), 4, 1'b0);
        step('0, 4, 1'b0);
        chk("look_up", 32'(bus.target_floor), 32'd6);
        ride(4, 6);
        door_wait(6, '0);
        step('0, 6, 1'b0);
        chk("look_rev", 32'(bus.target_floor), 32'd2);
        chk("look_rev_dir", 32'(bus.dir_up), 32'd0);
        ride(6, 2);
        door_wait(2, '0);

        // Retarget onto a call passed on the way; call behind stays.
        step(NF'(1) << 7, 1, 1'b0);
        step('0, 1, 1'b0);
        chk("serve7", 32'(bus.target_floor), 32'd7);
        step((NF'(1) << 3) | (NF'(1) << 1), 2, 1'b0);
        step('0, 2, 1'b0);
        chk("retarget", 32'(bus.target_floor), 32'd3);
        chk("behind_pend", 32'(bus.pending[1]), 32'd1);
        step('0, 3, 1'b1);
        door_wait(3, '0);
        step('0, 3, 1'b0);
        step('0, 4, 1'b1);
        chk("spur_tvalid", 32'(bus.target_valid), 32'd1);
        chk("spur_pend", 32'(bus.pending), 32'h082);
        ride(4, 7);
        door_wait(7, '0);
        step('0, 7, 1'b0);
        ride(7, 1);
        door_wait(1, '0);

        // Hall call at the car's own floor, repeated while open.
        step(NF'(1) << 3, 3, 1'b0);
        step('0, 3, 1'b0);
        chk("own_door", 32'(bus.door_open), 32'd1);
        chk("own_tvalid", 32'(bus.target_valid), 32'd0);
        door_wait(3, NF'(1) << 3);
        chk("own_pend3", 32'(bus.pending[3]), 32'd0);

        // Reset while the door is open with calls queued.
        step(NF'(1), 0, 1'b0);
        step('0, 0, 1'b0);
        step(NF'(9'h1A0), 0, 1'b0);
        chk("pre_rst_pend", 32'(bus.pending), 32'h1A0);
        rst_n = 1'b0;
        #1;
        reset_vals("async");
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step('0, 0, 1'b0);
        chk("post_rst_pend", 32'(bus.pending), 32'd0);
        chk("post_rst_tv", 32'(bus.target_valid), 32'd0);

        // Random calls with a crude motion block and input glitches.
        pos = 0;
        for (int c = 0; c < 4000; c++) begin
            calls = '0;
            if ($urandom_range(0, 7) == 0)
                calls[$urandom_range(0, NF - 1)] = 1'b1;
            if ($urandom_range(0, 29) == 0)
                calls[$urandom_range(0, NF - 1)] = 1'b1;
            arr = 1'b0;
            if (bus.target_valid) begin
                if (pos != int'(bus.target_floor)) begin
                    if ($urandom_range(0, 2) == 0)
                        pos += (int'(bus.target_floor) > pos) ? 1 : -1;
                end else if ($urandom_range(0, 1) == 0) begin
                    arr = 1'b1;
                end
            end
            if ($urandom_range(0, 24) == 0) arr = 1'b1;
            cfd = pos;
            if ($urandom_range(0, 39) == 0) cfd = $urandom_range(NF, 15);
            step(calls, cfd, arr);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
